pipeline_controller: RTL
========================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall/flush performance counters.
REQ-002 SHALL have parameter WAIT_MAX, default 255: memory-wait cycles before timeout is flagged.
REQ-003 SHALL have port clk  in  1  single rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port src1, src2  in  4 each  ID-stage source register numbers.
REQ-006 SHALL have port hazardTwoSrc  in  1  ID instruction reads src2.
REQ-007 SHALL have port idWbEn, idMemRead  in  1 each  ID instruction writes back / is a load.
REQ-008 SHALL have port idDest  in  4  ID instruction destination.
REQ-009 SHALL have port fwdEn  in  1  forwarding unit present in EXE.
REQ-010 SHALL have port branchTaken  in  1  EXE resolved a taken branch.
REQ-011 SHALL have port memReq, memReady  in  1 each  MEM-stage SRAM access pending / completed.
REQ-012 SHALL have ports freezeIf, freezeId, bubble, flush, freezeAll  out  1 each  pipeline control.
REQ-013 SHALL have port state  out  2  FSM state (RUN=0, MEM_WAIT=1, FLUSH=2).
REQ-014 SHALL have ports stallCnt, flushCnt  out  CNT_W each; memTimeout  out  1.

Function
REQ-015 SHALL keep a two-entry scoreboard: EXE slot {valid, dest, memRead} and MEM slot {valid, dest}.
REQ-016 SHALL, each cycle with freezeAll=0, shift: MEM slot <= EXE slot; EXE slot <= {idWbEn, idDest, idMemRead} unless bubble or flush, in which case EXE slot valid <= 0.
REQ-017 SHALL define a match as: slot valid, and dest==src1, or (hazardTwoSrc and dest==src2).
REQ-018 SHALL, with fwdEn=0, raise hazard on an EXE or MEM slot match; with fwdEn=1, raise it only on an EXE slot match with memRead=1 (load-use).
REQ-019 SHALL drive freezeIf=freezeId=bubble=1 combinationally in the hazard cycle, zero-cycle latency.
REQ-020 SHALL, in RUN, on branchTaken: assert flush for that cycle, suppress hazard outputs, go to FLUSH.
REQ-021 SHALL, in FLUSH: assert flush one further cycle, clear the EXE slot, return to RUN.
REQ-022 SHALL, in RUN or FLUSH, on memReq=1 and memReady=0: assert freezeAll combinationally, go to MEM_WAIT.
REQ-023 SHALL, in MEM_WAIT: hold freezeAll=1, scoreboard and state frozen, ignore branchTaken; on memReady=1, deassert freezeAll that cycle and go to RUN.
REQ-024 SHALL apply priority freezeAll > flush > hazard stall on simultaneous events; a flush deferred by MEM_WAIT is taken on the first RUN cycle after it (branchTaken still held by the frozen EXE stage).
REQ-025 SHALL count MEM_WAIT cycles; memTimeout SHALL go high when the count reaches WAIT_MAX, stay high until the state leaves MEM_WAIT, and the count SHALL clear on exit.
REQ-026 SHALL increment stallCnt per bubble cycle and flushCnt per flush cycle; both saturate at all-ones with no wrap-around.
REQ-027 SHALL never treat register number 15 (PC) as a hazard source.

Reset
REQ-028 SHALL, while rst=0, force state=RUN, clear both scoreboard slots, counters and wait count; all outputs 0.
REQ-029 SHALL abandon any MEM_WAIT or FLUSH in progress when reset asserts mid-operation, with no residual flush or freeze after release.

Structure
REQ-030 SHALL take state encodings and the PC register number (15) from the shared core package.
REQ-031 SHALL place the two-slot scoreboard in one sub-module, hazard_scoreboard; FSM and counters stay at top level.

Verification
REQ-032 fwdEn=0, EXE slot dest=3, ID src1=3 -> bubble=freezeIf=freezeId=1 one cycle, stallCnt 0->1.
REQ-033 fwdEn=1, EXE slot load dest=5, ID src2=5, hazardTwoSrc=1 -> one bubble; with hazardTwoSrc=0 -> no bubble.
REQ-034 branchTaken pulse in RUN -> flush high two cycles (RUN, FLUSH), flushCnt=2, EXE slot invalid.
REQ-035 memReq=1, memReady low 4 cycles -> freezeAll high 4 cycles, state=1, scoreboard unchanged; with WAIT_MAX=3, memTimeout rises on cycle 3.
REQ-036 memReq and branchTaken together -> freezeAll first, flush on the first cycle after memReady; rst low during MEM_WAIT -> state=0, all outputs 0.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared core definitions: controller state encodings, PC register number, scoreboard slot layouts.
// Pure declarations; no latency or backpressure of its own.
package pipeline_controller_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef struct packed {
    logic       vld;
    logic [3:0] dest;
    logic       mem_rd;
  } exe_slot_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] dest;
  } mem_slot_t;

  // The PC is produced outside the register file, so it never creates a dependency.
  function automatic logic slot_match(input logic vld, input logic [3:0] dest,
                                      input logic [3:0] src1, input logic [3:0] src2,
                                      input logic two_src);
    return vld && (((dest == src1) && (src1 != PC_REG)) ||
                   (two_src && (dest == src2) && (src2 != PC_REG)));
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_scoreboard.sv
// Two-slot (EXE, MEM) destination scoreboard with combinational hazard detect on ID sources.
// Zero-cycle hazard latency; slots hold while advance is low.
module hazard_scoreboard
  import pipeline_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       kill,
  input  logic       id_wb_en,
  input  logic       id_mem_read,
  input  logic [3:0] id_dest,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       two_src,
  input  logic       fwd_en,
  output logic       hazard
);

  exe_slot_t exe_slot;
  mem_slot_t mem_slot;
  logic      exe_hit;
  logic      mem_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_slot <= '0;
      mem_slot <= '0;
    end else if (advance) begin
      mem_slot.vld    <= exe_slot.vld;
      mem_slot.dest   <= exe_slot.dest;
      exe_slot.vld    <= id_wb_en && !kill;
      exe_slot.dest   <= id_dest;
      exe_slot.mem_rd <= id_mem_read;
    end
  end

  assign exe_hit = slot_match(exe_slot.vld, exe_slot.dest, src1, src2, two_src);
  assign mem_hit = slot_match(mem_slot.vld, mem_slot.dest, src1, src2, two_src);

  // With forwarding only a load still in EXE cannot be bypassed in time.
  assign hazard = fwd_en ? (exe_hit && exe_slot.mem_rd) : (exe_hit || mem_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline control FSM (RUN/MEM_WAIT/FLUSH): stall, flush and freeze generation plus perf counters.
// Controls are combinational (zero latency); freezeAll > flush > hazard stall.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             hazardTwoSrc,
  input  logic             idWbEn,
  input  logic             idMemRead,
  input  logic [3:0]       idDest,
  input  logic             fwdEn,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             freezeIf,
  output logic             freezeId,
  output logic             bubble,
  output logic             flush,
  output logic             freezeAll,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic             memTimeout
);

  localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);

  logic [1:0]      st_q;
  logic [1:0]      st_d;
  logic [WC_W-1:0] wait_cnt;
  logic            hazard;
  logic            freeze_c;
  logic            flush_c;
  logic            stall_c;

  always_comb begin
    st_d     = st_q;
    freeze_c = 1'b0;
    flush_c  = 1'b0;
    if (rst) begin
      case (st_q)
        ST_MEM_WAIT: begin
          if (memReady) st_d = ST_RUN;
          else          freeze_c = 1'b1;
        end
        default: begin
          if (memReq && !memReady) begin
            freeze_c = 1'b1;
            st_d     = ST_MEM_WAIT;
          end else if (st_q == ST_FLUSH) begin
            flush_c = 1'b1;
            st_d    = ST_RUN;
          end else if (branchTaken) begin
            flush_c = 1'b1;
            st_d    = ST_FLUSH;
          end
        end
      endcase
    end
  end

  assign stall_c   = rst && !freeze_c && !flush_c && hazard;
  assign freezeIf  = stall_c;
  assign freezeId  = stall_c;
  assign bubble    = stall_c;
  assign flush     = flush_c;
  assign freezeAll = freeze_c;
  assign state     = st_q;

  // The cycle being counted is included, so the flag rises on the WAIT_MAX-th frozen cycle.
  assign memTimeout = (st_q == ST_MEM_WAIT) && ((int'(wait_cnt) + 1) >= WAIT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_RUN;
      wait_cnt <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      st_q <= st_d;
      if (st_d == ST_MEM_WAIT) begin
        if (wait_cnt != WC_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (stall_c && (stallCnt != {CNT_W{1'b1}})) stallCnt <= stallCnt + 1'b1;
      if (flush_c && (flushCnt != {CNT_W{1'b1}})) flushCnt <= flushCnt + 1'b1;
    end
  end

  hazard_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .advance     (!freeze_c),
    .kill        (stall_c || flush_c),
    .id_wb_en    (idWbEn),
    .id_mem_read (idMemRead),
    .id_dest     (idDest),
    .src1        (src1),
    .src2        (src2),
    .two_src     (hazardTwoSrc),
    .fwd_en      (fwdEn),
    .hazard      (hazard)
  );

endmodule
